// File: rtl/l2_tag_assoc_unit.sv
// rtl/l2_tag_assoc_unit.sv - N-way set-associative L2 tag store, true-LRU, modelled hit/miss response delay
// Optional macro L2TAG_SAME_LINE_BYPASS_EN: repeat request to the last completed line answers as a zero-delay hit.
module l2_tag_assoc_unit #(
  parameter int ADDR_W         = 32,
  parameter int LINE_BYTES_LOG = 7,
  parameter int SETS_LOG       = 10,
  parameter int WAYS           = 4,
  parameter int HIT_DELAY      = 20,
  parameter int MISS_DELAY     = 400,
  parameter int DELAY_W        = 10,
  localparam int WAY_W         = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               req_valid,
  input  logic [ADDR_W-1:0]  req_addr,
  output logic               req_ready,
  output logic               rsp_valid,
  output logic               rsp_hit,
  output logic [WAY_W-1:0]   rsp_way,
  output logic [DELAY_W-1:0] rsp_delay,
  input  logic               fill_valid,
  input  logic [ADDR_W-1:0]  fill_addr,
  output logic               evict_valid,
  output logic [ADDR_W-1:0]  evict_addr,
  input  logic               flush
);
  localparam int SETS   = 1 << SETS_LOG;
  localparam int TAG_W  = ADDR_W - SETS_LOG - LINE_BYTES_LOG;
  localparam int LINE_W = ADDR_W - LINE_BYTES_LOG;

  typedef logic [WAYS-1:0][WAY_W-1:0] age_row_t;
  typedef logic [WAYS-1:0][TAG_W-1:0] tag_row_t;
  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_WAIT} state_t;

  // Touched way becomes age 0; ways younger than its old age slide one step older.
  function automatic age_row_t lru_touch(input age_row_t row, input logic [WAY_W-1:0] way);
    age_row_t res;
    res = row;
    for (int i = 0; i < WAYS; i++) begin
      if (WAY_W'(i) == way) res[i] = '0;
      else if (row[i] < row[way]) res[i] = row[i] + 1'b1;
    end
    return res;
  endfunction

  state_t             r_state, w_next_state;
  tag_row_t           r_tag   [SETS];
  logic [WAYS-1:0]    r_valid [SETS];
  age_row_t           r_age   [SETS];
  logic [LINE_W-1:0]  r_line;
  logic [DELAY_W-1:0] r_cnt;
  logic               r_rsp_hit;
  logic [WAY_W-1:0]   r_rsp_way;
  logic [DELAY_W-1:0] r_rsp_delay;
  logic               r_evict_valid;
  logic [ADDR_W-1:0]  r_evict_addr;

  logic [SETS_LOG-1:0] w_lu_idx, w_f_idx;
  logic [TAG_W-1:0]    w_lu_tag, w_f_tag;
  logic                w_lu_match, w_lu_upd, w_bypass;
  logic [WAY_W-1:0]    w_lu_way;
  age_row_t            w_lu_row, w_f_base, w_f_row;
  logic                w_f_hit, w_f_inv, w_f_evict, w_fill_do;
  logic [WAY_W-1:0]    w_f_hit_way, w_f_inv_way, w_f_lru_way, w_f_way;
  logic [LINE_W-1:0]   w_evict_line;
  logic [DELAY_W-1:0]  w_delay;
  logic                w_unused;

  assign w_lu_idx     = r_line[SETS_LOG-1:0];
  assign w_lu_tag     = r_line[LINE_W-1:SETS_LOG];
  assign w_f_idx      = fill_addr[SETS_LOG+LINE_BYTES_LOG-1:LINE_BYTES_LOG];
  assign w_f_tag      = fill_addr[ADDR_W-1:SETS_LOG+LINE_BYTES_LOG];
  assign w_fill_do    = fill_valid && !flush;
  assign w_evict_line = {r_tag[w_f_idx][w_f_way], w_f_idx};
  assign w_unused     = ^{req_addr[LINE_BYTES_LOG-1:0], fill_addr[LINE_BYTES_LOG-1:0]};

  always_comb begin
    w_lu_match = 1'b0;
    w_lu_way   = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (r_valid[w_lu_idx][i] && r_tag[w_lu_idx][i] == w_lu_tag) begin
        w_lu_match = 1'b1;
        w_lu_way   = WAY_W'(i);
      end
    end
    w_lu_row = lru_touch(r_age[w_lu_idx], w_lu_way);
    w_lu_upd = (r_state == S_LOOKUP) && w_lu_match && !w_bypass;
    w_delay  = w_bypass ? '0 : (w_lu_match ? DELAY_W'(HIT_DELAY) : DELAY_W'(MISS_DELAY));
  end

  // Fill works on the set's ages after any same-cycle lookup hit, so the fill lands last.
  always_comb begin
    w_f_base    = (w_lu_upd && w_lu_idx == w_f_idx) ? w_lu_row : r_age[w_f_idx];
    w_f_hit     = 1'b0;
    w_f_hit_way = '0;
    w_f_inv     = 1'b0;
    w_f_inv_way = '0;
    w_f_lru_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (r_valid[w_f_idx][i] && r_tag[w_f_idx][i] == w_f_tag) begin
        w_f_hit     = 1'b1;
        w_f_hit_way = WAY_W'(i);
      end
      if (!r_valid[w_f_idx][i]) begin
        w_f_inv     = 1'b1;
        w_f_inv_way = WAY_W'(i);
      end
      if (w_f_base[i] == WAY_W'(WAYS - 1)) w_f_lru_way = WAY_W'(i);
    end
    w_f_way   = w_f_hit ? w_f_hit_way : (w_f_inv ? w_f_inv_way : w_f_lru_way);
    w_f_evict = !w_f_hit && !w_f_inv;
    w_f_row   = lru_touch(w_f_base, w_f_way);
  end

`ifdef L2TAG_SAME_LINE_BYPASS_EN
  logic              r_last_vld;
  logic [LINE_W-1:0] r_last_line;

  assign w_bypass = r_last_vld && (r_last_line == r_line);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_vld  <= 1'b0;
      r_last_line <= '0;
    end else if (!stall) begin
      if (flush) begin
        r_last_vld <= 1'b0;
      end else begin
        if (rsp_valid) begin
          r_last_vld  <= 1'b1;
          r_last_line <= r_line;
        end
        if (w_fill_do && w_f_evict && w_evict_line == (rsp_valid ? r_line : r_last_line))
          r_last_vld <= 1'b0;
      end
    end
  end
`else
  assign w_bypass = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else if (!stall) r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (req_valid) w_next_state = S_LOOKUP;
      S_LOOKUP: w_next_state = S_WAIT;
      S_WAIT:   if (r_cnt == '0) w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (r_state == S_IDLE);
    rsp_valid = (r_state == S_WAIT) && (r_cnt == '0);
  end

  always_ff @(posedge clk) begin
    if (!stall && w_fill_do) r_tag[w_f_idx][w_f_way] <= w_f_tag;
    if (!stall && r_state == S_IDLE && req_valid) r_line <= req_addr[ADDR_W-1:LINE_BYTES_LOG];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        for (int w = 0; w < WAYS; w++) r_age[s][w] <= WAY_W'(w);
      end
      r_cnt         <= '0;
      r_rsp_hit     <= 1'b0;
      r_rsp_way     <= '0;
      r_rsp_delay   <= '0;
      r_evict_valid <= 1'b0;
      r_evict_addr  <= '0;
    end else if (!stall) begin
      if (w_lu_upd) r_age[w_lu_idx] <= w_lu_row;
      if (w_fill_do) r_age[w_f_idx] <= w_f_row;
      if (flush) begin
        for (int s = 0; s < SETS; s++) r_valid[s] <= '0;
      end else if (w_fill_do) begin
        r_valid[w_f_idx][w_f_way] <= 1'b1;
      end
      r_evict_valid <= w_fill_do && w_f_evict;
      if (w_fill_do && w_f_evict) r_evict_addr <= {w_evict_line, {LINE_BYTES_LOG{1'b0}}};
      if (r_state == S_LOOKUP) begin
        r_rsp_hit   <= w_lu_match || w_bypass;
        r_rsp_way   <= w_bypass ? r_rsp_way : (w_lu_match ? w_lu_way : '0);
        r_rsp_delay <= w_delay;
        r_cnt       <= w_delay;
      end else if (r_state == S_WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign rsp_hit     = r_rsp_hit;
  assign rsp_way     = r_rsp_way;
  assign rsp_delay   = r_rsp_delay;
  assign evict_valid = r_evict_valid;
  assign evict_addr  = r_evict_addr;

endmodule

// File: tb/tb_l2_tag_assoc_unit.sv
// tb/tb_l2_tag_assoc_unit.sv - table-driven scoreboard bench for l2_tag_assoc_unit
module tb_l2_tag_assoc_unit;
  logic        clk = 1'b0, reset = 1'b1, stall = 1'b0, req_valid = 1'b0, fill_valid = 1'b0, flush = 1'b0;
  logic [31:0] req_addr = '0, fill_addr = '0;
  logic        req_ready, rsp_valid, rsp_hit, evict_valid;
  logic [1:0]  rsp_way;
  logic [9:0]  rsp_delay;
  logic [31:0] evict_addr;
  int checks = 0, errors = 0, cyc = 0;

  typedef struct {logic hit; logic [1:0] way; int delay; int at;} exp_t;
  typedef struct {bit is_fill; logic [31:0] addr; logic flag; logic [1:0] way; int delay; logic [31:0] eaddr;} vec_t;
  exp_t sb[$];
  exp_t m_e;
  vec_t vt[20];

  l2_tag_assoc_unit dut (
    .clk(clk), .reset(reset), .stall(stall),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_way(rsp_way), .rsp_delay(rsp_delay),
    .fill_valid(fill_valid), .fill_addr(fill_addr),
    .evict_valid(evict_valid), .evict_addr(evict_addr), .flush(flush)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && rsp_valid && !stall) begin
      if (sb.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
      else begin
        m_e = sb.pop_front();
        chk("rsp_hit", 32'(rsp_hit), 32'(m_e.hit));
        chk("rsp_way", 32'(rsp_way), 32'(m_e.way));
        chk("rsp_delay", 32'(rsp_delay), 32'(m_e.delay));
        chk("rsp_cycle", cyc, m_e.at);
      end
    end
  end

  task automatic do_req(input logic [31:0] a, input bit push, input logic h, input logic [1:0] w,
                        input int d, input int extra);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("req_ready_timeout", 32'd0, 32'd1);
    req_valid = 1'b1;
    req_addr  = a;
    if (push) begin
      e.hit = h; e.way = w; e.delay = d; e.at = cyc + 2 + d + extra;
      sb.push_back(e);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", sb.size(), 32'd0);
  endtask

  task automatic do_fill(input logic [31:0] a, input logic ev, input logic [31:0] ea);
    @(negedge clk);
    fill_valid = 1'b1;
    fill_addr  = a;
    @(negedge clk);
    fill_valid = 1'b0;
    chk("evict_valid", 32'(evict_valid), 32'(ev));
    if (ev) chk("evict_addr", evict_addr, ea);
    @(negedge clk);
    chk("evict_pulse_end", 32'(evict_valid), 32'd0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_hit", 32'(rsp_hit), 32'd0);
    chk("rst_rsp_way", 32'(rsp_way), 32'd0);
    chk("rst_rsp_delay", 32'(rsp_delay), 32'd0);
    chk("rst_evict_valid", 32'(evict_valid), 32'd0);
    chk("rst_evict_addr", evict_addr, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    // Set 1 holds tags 1..6 at various times; ages walk through evictions of tags 2 and 3.
    vt[0]  = '{1'b0, 32'h00020080, 1'b0, 2'd0, 400, 32'h0};
    vt[1]  = '{1'b1, 32'h00020080, 1'b0, 2'd0, 0,   32'h0};
    vt[2]  = '{1'b0, 32'h00020090, 1'b1, 2'd0, 20,  32'h0};
    vt[3]  = '{1'b1, 32'h00040080, 1'b0, 2'd0, 0,   32'h0};
    vt[4]  = '{1'b1, 32'h00060080, 1'b0, 2'd0, 0,   32'h0};
    vt[5]  = '{1'b1, 32'h00080080, 1'b0, 2'd0, 0,   32'h0};
    vt[6]  = '{1'b0, 32'h00020080, 1'b1, 2'd0, 20,  32'h0};
    vt[7]  = '{1'b1, 32'h000A0080, 1'b1, 2'd0, 0,   32'h00040080};
    vt[8]  = '{1'b0, 32'h00040080, 1'b0, 2'd0, 400, 32'h0};
    vt[9]  = '{1'b0, 32'h000A0080, 1'b1, 2'd1, 20,  32'h0};
    vt[10] = '{1'b0, 32'h00080080, 1'b1, 2'd3, 20,  32'h0};
    vt[11] = '{1'b1, 32'h00020080, 1'b0, 2'd0, 0,   32'h0};
    vt[12] = '{1'b1, 32'h000C0080, 1'b1, 2'd0, 0,   32'h00060080};
    vt[13] = '{1'b0, 32'h00060080, 1'b0, 2'd0, 400, 32'h0};
    vt[14] = '{1'b0, 32'h000C00FF, 1'b1, 2'd2, 20,  32'h0};
    vt[15] = '{1'b1, 32'hFFFFFF80, 1'b0, 2'd0, 0,   32'h0};
    vt[16] = '{1'b0, 32'hFFFFFFFF, 1'b1, 2'd0, 20,  32'h0};
    vt[17] = '{1'b0, 32'h00000000, 1'b0, 2'd0, 400, 32'h0};
    vt[18] = '{1'b1, 32'h00000100, 1'b0, 2'd0, 0,   32'h0};
    vt[19] = '{1'b0, 32'h00000104, 1'b1, 2'd0, 20,  32'h0};

    repeat (3) @(negedge clk);
    chk_reset_outputs();
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      if (vt[i].is_fill) do_fill(vt[i].addr, vt[i].flag, vt[i].eaddr);
      else begin
        do_req(vt[i].addr, 1'b1, vt[i].flag, vt[i].way, vt[i].delay, 0);
        drain();
      end
    end

    // Flush with a concurrent fill: the fill is dropped and the set comes back empty.
    @(negedge clk);
    flush = 1'b1; fill_valid = 1'b1; fill_addr = 32'h00080080;
    @(negedge clk);
    flush = 1'b0; fill_valid = 1'b0;
    do_req(32'h00080080, 1'b1, 1'b0, 2'd0, 400, 0);
    drain();
    do_req(32'h00020080, 1'b1, 1'b0, 2'd0, 400, 0);
    drain();
    do_fill(32'h00020080, 1'b0, 32'h0);

    // Stall 50 cycles inside WAIT of a hit.
    do_req(32'h00020080, 1'b1, 1'b1, 2'd0, 20, 50);
    repeat (5) @(posedge clk);
    #1 stall = 1'b1;
    repeat (50) @(posedge clk);
    #1 stall = 1'b0;
    chk("busy_req_ready", 32'(req_ready), 32'd0);
    drain();

    // Stall exactly in the response cycle: rsp_valid must hold.
    do_req(32'h00020080, 1'b1, 1'b1, 2'd0, 20, 3);
    repeat (21) @(posedge clk);
    #1 stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stalled_rsp_valid", 32'(rsp_valid), 32'd1);
      @(posedge clk);
      #1;
    end
    stall = 1'b0;
    drain();

    // Reset during WAIT drops the in-flight request and all valid bits.
    do_req(32'h00020080, 1'b0, 1'b1, 2'd0, 20, 0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_outputs();
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("no_rsp_after_reset", sb.size(), 32'd0);
    do_req(32'h00020080, 1'b1, 1'b0, 2'd0, 400, 0);
    drain();

    do_fill(32'h00020080, 1'b0, 32'h0);
    do_req(32'h00020080, 1'b1, 1'b1, 2'd0, 20, 0);
    drain();
`ifdef L2TAG_SAME_LINE_BYPASS_EN
    do_req(32'h00020080, 1'b1, 1'b1, 2'd0, 0, 0);
`else
    do_req(32'h00020080, 1'b1, 1'b1, 2'd0, 20, 0);
`endif
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/l2_tag_assoc_unit.md
Name: l2_tag_assoc_unit

Overview:
- Parametrised, N-way set-associative L2 tag store with true-LRU replacement.
- Sits between the coalescer and the DRAM timing model.
- Per request: one lookup, then a modelled hit or miss delay, then a single response.
- Separate fill port installs lines and reports evicted victims; flush clears all valid bits.

Parameters:
- ADDR_W, 32, byte address width.
- LINE_BYTES_LOG, 7, log2 of line size in bytes.
- SETS_LOG, 10, log2 of number of sets.
- WAYS, 4, associativity; power of 2, range 1..16.
- HIT_DELAY, 20, response delay in cycles on hit.
- MISS_DELAY, 400, response delay in cycles on miss.
- DELAY_W, 10, width of rsp_delay and the countdown counter; must hold MISS_DELAY.

Ports:
- clk, in, 1, clock.
- reset, in, 1, synchronous, active-high.
- stall, in, 1, global freeze.
- req_valid, in, 1, lookup request.
- req_addr, in, ADDR_W, lookup byte address.
- req_ready, out, 1, lookup accepted this cycle when req_valid & req_ready & ~stall.
- rsp_valid, out, 1, response strobe.
- rsp_hit, out, 1, lookup hit.
- rsp_way, out, log2(WAYS) (min 1), hitting way; 0 on miss.
- rsp_delay, out, DELAY_W, modelled delay applied.
- fill_valid, in, 1, install line.
- fill_addr, in, ADDR_W, line address to install.
- evict_valid, out, 1, one-cycle pulse: fill displaced a valid line.
- evict_addr, out, ADDR_W, line-aligned address of the displaced line; low LINE_BYTES_LOG bits are 0.
- flush, in, 1, invalidate all lines.

Behaviour:
- Address split: index = addr[SETS_LOG+LINE_BYTES_LOG-1 : LINE_BYTES_LOG]; tag = addr[ADDR_W-1 : SETS_LOG+LINE_BYTES_LOG].
- Reset: state IDLE; all valid bits 0; LRU age of way i in every set = i; counter 0.
- Reset output values: req_ready 1, rsp_valid 0, rsp_hit 0, rsp_way 0, rsp_delay 0, evict_valid 0, evict_addr 0.
- Reset mid-operation discards any in-flight request; no response is produced for it.
- stall=1 freezes every register (state, counter, tags, LRU, outputs). fill_valid and flush are ignored while stalled; the source holds them.
- FSM:
  - IDLE: req_ready=1. On accept (edge k), latch the address and go to LOOKUP.
  - LOOKUP (cycle k+1): compare tag against all valid ways of the set. Lowest-index matching way wins. Latch rsp_hit, rsp_way, and rsp_delay = hit ? HIT_DELAY : MISS_DELAY. Load the counter with rsp_delay. Go to WAIT. A hit marks that way MRU.
  - WAIT: counter decrements each unstalled cycle. When the counter is 0, rsp_valid=1 for that cycle and the next state is IDLE.
  - Response timing: rsp_valid is high in cycle k+2+rsp_delay. Next accept is possible at cycle k+3+rsp_delay.
  - Once latched, rsp_hit, rsp_way and rsp_delay hold until the next LOOKUP.
- Miss does not allocate; only fill allocates.
- Fill (any state, ~stall):
  - If the tag is already present in the set: mark that way MRU; no eviction.
  - Otherwise the victim is the lowest-index invalid way, else the LRU way (max age). Write tag, set valid, mark MRU.
  - If the victim was valid: evict_valid pulses the next cycle, with evict_addr = {old tag, index, zeros}.
- LRU update: the touched way's age becomes 0. Ways with age lower than its old age increment. Ages always form a permutation of 0..WAYS-1.
- Same-cycle fill and LOOKUP: the lookup sees pre-fill state. When both target the same set, the LRU update is applied with fill last.
- flush: all valid bits are 0 from the next cycle; LRU is unchanged. A concurrent fill is dropped. An in-flight response completes with its latched values.

Optional Feature:
- Macro: L2TAG_SAME_LINE_BYPASS_EN.
- Defined: a request whose line address equals the previously completed request's line is treated as a hit with rsp_delay=0 and rsp_way equal to the last rsp_way. The tag compare is skipped and rsp_valid rises at k+2. The remembered line is cleared by reset, by flush, and by any eviction of that line.
- Undefined: no bypass; every request does a full lookup.

Test Plan:
- Cold miss: after reset, req 0x00020080 (tag 1, index 1) -> rsp_valid at k+402; rsp_hit=0, rsp_delay=400.
- Fill then hit: fill 0x00020080, then req 0x00020090 -> rsp at k+22; rsp_hit=1, rsp_way=0, rsp_delay=20.
- LRU eviction: fill 0x00020080, 0x00040080, 0x00060080, 0x00080080; req hits 0x00020080; fill 0x000A0080 -> next cycle evict_valid=1, evict_addr=0x00040080; a later req to 0x00040080 misses.
- Flush: fill 4 lines, pulse flush, req 0x00020080 -> miss with delay 400; evict_valid stays 0 on the next fill.
- Stall: hold stall=1 for 50 cycles during WAIT of a hit -> rsp_valid at k+72. rsp_valid held high while stall is asserted in its cycle.
- Bypass (macro defined): two back-to-back reqs to 0x00020080 after its fill -> second response has rsp_delay=0 at k+2. With macro undefined the second has delay 20.
